joystick_spi_reader: RTL and testbench
======================================

// Module: joystick_spi_reader
// PURPOSE
//  Polls the PmodJSTK joystick over SPI (mode 0, MSB first) and publishes debounced-free
//  10-bit X/Y positions, button bits and a registered move_detect flag to the bop-it game
//  core. It sits directly upstream of the game FSM, replacing ad-hoc joystick sampling.
//  One 5-byte transaction per poll period; outputs update atomically at transaction end.
// PARAMETERS
//  SCLK_HALF     50         masterclk cycles per SCLK half-period (1 MHz SCLK at 100 MHz)
//  CS_SETUP_CYC  1500       cycles from cs falling to first SCLK rise (15 us)
//  BYTE_GAP_CYC  1000       idle cycles between bytes, SCLK low, cs held low (10 us)
//  POLL_CYC      1000000    cycles from one transaction start to the next (10 ms)
//  CENTER        10'd512    joystick rest value
//  THRESHOLD     10'd200    deflection beyond which move_detect asserts
// PORTS
//  clk          in   1   system clock (masterclk)
//  rst          in   1   synchronous reset, active-low
//  led          in   2   PmodJSTK LED control bits, sent in byte 0
//  miso         in   1   SPI data from joystick
//  mosi         out  1   SPI data to joystick
//  sclk         out  1   SPI clock, idle low
//  cs           out  1   SPI chip select, active-low
//  x_pos        out  10  last complete X sample
//  y_pos        out  10  last complete Y sample
//  buttons      out  3   {stick_btn, btn2, btn1} from byte 4 bits [2:0]
//  move_detect  out  1   1 when X or Y deflection > THRESHOLD
//  sample_valid out  1   one-cycle pulse when outputs updated
// BEHAVIOUR
//  Reset (rst=0 at clk edge): cs=1, sclk=0, mosi=0, x_pos=y_pos=CENTER, buttons=0,
//   move_detect=0, sample_valid=0, FSM->IDLE, all counters 0. Reset mid-transaction: cs=1
//   the following cycle, partial bytes discarded, no sample_valid, outputs = reset values.
//  FSM: IDLE -(poll counter hits POLL_CYC-1, counter wraps to 0)-> SETUP (cs=0)
//   -(CS_SETUP_CYC cycles)-> XFER -(8 bits done)-> GAP if byte<4 else DONE;
//   GAP -(BYTE_GAP_CYC cycles)-> XFER; DONE (1 cycle: cs=1, latch outputs) -> IDLE.
//   Poll counter free-runs in all states; first transaction starts POLL_CYC cycles after reset.
//  Bit timing: each bit = SCLK_HALF cycles low then SCLK_HALF cycles high. mosi changes
//   only while sclk low (at start of low phase); miso sampled in the cycle sclk rises.
//  mosi bytes: byte0 = 8'h80 | {6'b0, led}; bytes1-4 = 8'h00. led sampled on SETUP entry.
//  miso bytes: b0=X[7:0], b1=X[9:8] in [1:0], b2=Y[7:0], b3=Y[9:8], b4=buttons in [2:0];
//   unused high bits ignored.
//  DONE: x_pos, y_pos, buttons, move_detect and sample_valid=1 all register in same edge.
//   move_detect = (x>CENTER+THRESHOLD)|(x<CENTER-THRESHOLD)|same for y; strict compares,
//   done in 11-bit unsigned to avoid wrap. Outputs hold between samples.
//  Latency: miso bit of byte4 bit0 -> outputs valid 1 cycle after final SCLK fall.
// STRUCTURE
//  Shared include jstk_defs.vh: FSM state encodings, byte count (5), LED command prefix 8'h80,
//   CENTER/THRESHOLD defaults.
//  Sub-module spi_byte_shifter: given start + tx byte, generates sclk/mosi for 8 bits,
//   returns rx byte + done pulse; top level owns cs, gaps, poll timer, assembly.
// TESTING (bench uses SCLK_HALF=2, CS_SETUP_CYC=6, BYTE_GAP_CYC=4, POLL_CYC=400)
//  1 Reset: hold rst=0 5 cycles -> cs=1, sclk=0, x_pos=y_pos=512, move_detect=0, no pulse.
//  2 Slave model returns 00,02,FF,01,03 -> x_pos=512, y_pos=511, buttons=3'b011,
//    move_detect=0, sample_valid exactly one cycle, exactly 40 SCLK rises with cs low.
//  3 X=713 (C9,02), Y=512 -> move_detect=1; X=712 -> 0; Y=311 (37,01) -> 1; Y=312 -> 0.
//  4 Timing: cs fall to first sclk rise >=6 cycles; sclk period 4; byte gap >=4 cycles
//    sclk low; mosi stable across every sclk rise; next cs fall 400 cycles after previous.
//  5 led=2'b01 -> mosi byte0 = 0x81, bytes1-4 = 0x00; led changed mid-xfer -> no effect.
//  6 rst=0 during byte 2 -> cs=1 next cycle, outputs=reset values, no sample_valid;
//    next transaction completes normally with new data.

Source files
------------

// File: rtl/joystick_spi_reader_pkg.sv
// Shared constants for the PmodJSTK poller: FSM encodings, transaction shape and rest/threshold defaults.
package joystick_spi_reader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int unsigned NUM_BYTES = 5;
  localparam logic [2:0]  LAST_BYTE = 3'(NUM_BYTES - 1);
  localparam logic [7:0]  LED_CMD   = 8'h80;

  localparam logic [9:0] CENTER_DEF    = 10'd512;
  localparam logic [9:0] THRESHOLD_DEF = 10'd200;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] buttons;
  } sample_t;

  // The low bound is tested as v + t < c so nothing underflows even if t > c.
  function automatic logic deflected(input logic [9:0] v, input logic [9:0] c,
                                     input logic [9:0] t);
    logic [10:0] v11;
    logic [10:0] c11;
    logic [10:0] t11;
    v11 = {1'b0, v};
    c11 = {1'b0, c};
    t11 = {1'b0, t};
    return (v11 > c11 + t11) || (v11 + t11 < c11);
  endfunction

endpackage

// File: rtl/joystick_spi_reader_if.sv
// SPI pin bundle between the joystick poller (master) and the PmodJSTK (slave).
interface joystick_spi_reader_if;
  logic miso;
  logic mosi;
  logic sclk;
  logic cs;

  modport master (input miso, output mosi, output sclk, output cs);
  modport slave  (output miso, input mosi, input sclk, input cs);
endinterface

// File: rtl/joystick_spi_reader_spi_byte_shifter.sv
// Mode-0 MSB-first byte shifter: start launches 8 bits (SCLK_HALF low, SCLK_HALF high each).
// done pulses in the cycle before the final SCLK fall, with rx_byte already complete.
module joystick_spi_reader_spi_byte_shifter #(
  parameter int unsigned SCLK_HALF = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done
);
  localparam int unsigned    HW        = $clog2(SCLK_HALF + 1);
  localparam logic [HW-1:0]  HALF_LAST = HW'(SCLK_HALF - 1);

  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [HW-1:0] half_q, half_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          half_end;

  always_comb begin
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    half_d   = half_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    done     = 1'b0;
    half_end = busy_q && (half_q == HALF_LAST);
    if (start && !busy_q) begin
      busy_d = 1'b1;
      sclk_d = 1'b0;
      mosi_d = tx_byte[7];
      tx_d   = {tx_byte[6:0], 1'b0};
      half_d = '0;
      bit_d  = 3'd0;
    end else if (busy_q) begin
      half_d = half_end ? '0 : half_q + 1'b1;
      if (half_end && !sclk_q) begin
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], miso};
      end else if (half_end) begin
        // Falling edge: start of the next low phase is the only place mosi moves.
        sclk_d = 1'b0;
        if (bit_q == 3'd7) begin
          busy_d = 1'b0;
          mosi_d = 1'b0;
          done   = 1'b1;
        end else begin
          bit_d  = bit_q + 1'b1;
          mosi_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      half_q <= '0;
      bit_q  <= 3'd0;
      tx_q   <= 8'h00;
      rx_q   <= 8'h00;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      half_q <= half_d;
      bit_q  <= bit_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign rx_byte = rx_q;
endmodule

// File: rtl/joystick_spi_reader.sv
// Polls a PmodJSTK every POLL_CYC cycles with one 5-byte SPI transaction and publishes X/Y/buttons.
// All outputs and the sample_valid pulse update together one cycle after the final SCLK fall.
module joystick_spi_reader
  import joystick_spi_reader_pkg::*;
#(
  parameter int unsigned SCLK_HALF    = 50,
  parameter int unsigned CS_SETUP_CYC = 1500,
  parameter int unsigned BYTE_GAP_CYC = 1000,
  parameter int unsigned POLL_CYC     = 1000000,
  parameter logic [9:0]  CENTER       = CENTER_DEF,
  parameter logic [9:0]  THRESHOLD    = THRESHOLD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            led,
  joystick_spi_reader_if.master spi,
  output logic [9:0]            x_pos,
  output logic [9:0]            y_pos,
  output logic [2:0]            buttons,
  output logic                  move_detect,
  output logic                  sample_valid
);
  localparam int unsigned   PW         = $clog2(POLL_CYC + 1);
  localparam int unsigned   TMAX       = (CS_SETUP_CYC > BYTE_GAP_CYC) ? CS_SETUP_CYC : BYTE_GAP_CYC;
  localparam int unsigned   TW         = $clog2(TMAX + 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(BYTE_GAP_CYC - 1);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    byte_q, byte_d;
  logic [1:0]    led_q, led_d;
  logic          cs_q, cs_d;
  logic [7:0]    x_lo_q, x_lo_d, y_lo_q, y_lo_d;
  logic [1:0]    x_hi_q, x_hi_d, y_hi_q, y_hi_d;
  logic [2:0]    btn_q, btn_d;
  sample_t       sample_q, sample_d;
  logic          move_q, move_d;
  logic          valid_q, valid_d;

  logic       poll_hit;
  logic       sh_start;
  logic       sh_done;
  logic [7:0] sh_tx;
  logic [7:0] sh_rx;
  logic       sclk_w;
  logic       mosi_w;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    byte_d   = byte_q;
    led_d    = led_q;
    x_lo_d   = x_lo_q;
    x_hi_d   = x_hi_q;
    y_lo_d   = y_lo_q;
    y_hi_d   = y_hi_q;
    btn_d    = btn_q;
    sample_d = sample_q;
    move_d   = move_q;
    valid_d  = 1'b0;
    sh_start = 1'b0;
    poll_hit = (poll_q == POLL_LAST);
    poll_d   = poll_hit ? '0 : poll_q + 1'b1;
    case (state_q)
      ST_IDLE: if (poll_hit) begin
        state_d = ST_SETUP;
        tmr_d   = '0;
        byte_d  = 3'd0;
        led_d   = led;
      end
      ST_SETUP, ST_GAP: if ((state_q == ST_SETUP) ? (tmr_q == SETUP_LAST) : (tmr_q == GAP_LAST)) begin
        state_d  = ST_XFER;
        tmr_d    = '0;
        sh_start = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      ST_XFER: if (sh_done) begin
        case (byte_q)
          3'd0:    x_lo_d = sh_rx;
          3'd1:    x_hi_d = sh_rx[1:0];
          3'd2:    y_lo_d = sh_rx;
          3'd3:    y_hi_d = sh_rx[1:0];
          default: btn_d  = sh_rx[2:0];
        endcase
        if (byte_q == LAST_BYTE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_GAP;
          byte_d  = byte_q + 1'b1;
        end
      end
      ST_DONE: begin
        sample_d.x       = {x_hi_q, x_lo_q};
        sample_d.y       = {y_hi_q, y_lo_q};
        sample_d.buttons = btn_q;
        move_d  = deflected({x_hi_q, x_lo_q}, CENTER, THRESHOLD) ||
                  deflected({y_hi_q, y_lo_q}, CENTER, THRESHOLD);
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // cs is registered from the next state so it drops on SETUP entry and rises on DONE entry.
    cs_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
  end

  assign sh_tx = (byte_q == 3'd0) ? (LED_CMD | {6'b0, led_q}) : 8'h00;

  joystick_spi_reader_spi_byte_shifter #(
    .SCLK_HALF (SCLK_HALF)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (sh_start),
    .tx_byte (sh_tx),
    .miso    (spi.miso),
    .sclk    (sclk_w),
    .mosi    (mosi_w),
    .rx_byte (sh_rx),
    .done    (sh_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      poll_q   <= '0;
      tmr_q    <= '0;
      byte_q   <= 3'd0;
      led_q    <= 2'b00;
      cs_q     <= 1'b1;
      x_lo_q   <= 8'h00;
      x_hi_q   <= 2'b00;
      y_lo_q   <= 8'h00;
      y_hi_q   <= 2'b00;
      btn_q    <= 3'b000;
      sample_q <= '{x: CENTER, y: CENTER, buttons: 3'b000};
      move_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      poll_q   <= poll_d;
      tmr_q    <= tmr_d;
      byte_q   <= byte_d;
      led_q    <= led_d;
      cs_q     <= cs_d;
      x_lo_q   <= x_lo_d;
      x_hi_q   <= x_hi_d;
      y_lo_q   <= y_lo_d;
      y_hi_q   <= y_hi_d;
      btn_q    <= btn_d;
      sample_q <= sample_d;
      move_q   <= move_d;
      valid_q  <= valid_d;
    end
  end

  assign spi.cs       = cs_q;
  assign spi.sclk     = sclk_w;
  assign spi.mosi     = mosi_w;
  assign x_pos        = sample_q.x;
  assign y_pos        = sample_q.y;
  assign buttons      = sample_q.buttons;
  assign move_detect  = move_q;
  assign sample_valid = valid_q;
endmodule

// File: tb/tb_joystick_spi_reader.sv
// Directed bench for joystick_spi_reader with a mode-0 PmodJSTK slave model and SPI timing monitor.
module tb_joystick_spi_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] led = 2'b00;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] buttons;
  logic       move_detect;
  logic       sample_valid;

  joystick_spi_reader_if spi();

  joystick_spi_reader #(
    .SCLK_HALF    (2),
    .CS_SETUP_CYC (6),
    .BYTE_GAP_CYC (4),
    .POLL_CYC     (400)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .led          (led),
    .spi          (spi),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .buttons      (buttons),
    .move_detect  (move_detect),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor / slave state, written only by the negedge block below.
  int          cyc = 0;
  logic [7:0]  slave_bytes [5];
  int          s_bit = 40;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_valid = 1'b0;
  int          rise_cnt = 0, per4_cnt = 0, gap_cnt = 0, gap_min = 1000;
  int          low_run = 0, last_rise = 0, setup_gap = 0;
  int          cs_fall_cyc = 0, prev_cs_fall_cyc = 0;
  int          mosi_unstable = 0, valid_cnt = 0, valid_long = 0;
  bit          first_pending = 1'b0;
  logic [39:0] mosi_cap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [7:0] cur;
    if (prev_cs && !spi.cs) begin
      prev_cs_fall_cyc = cs_fall_cyc;
      cs_fall_cyc      = cyc;
      first_pending    = 1'b1;
      low_run          = 0;
      s_bit            = 0;
    end else if (prev_sclk && !spi.sclk && !spi.cs) begin
      s_bit = s_bit + 1;
    end
    if (s_bit < 40) begin
      cur      = slave_bytes[s_bit / 8];
      spi.miso = cur[7 - (s_bit % 8)];
    end else begin
      spi.miso = 1'b0;
    end
    if (!spi.cs && !spi.sclk) low_run = low_run + 1;
    if (!prev_sclk && spi.sclk && !spi.cs) begin
      rise_cnt = rise_cnt + 1;
      mosi_cap = {mosi_cap[38:0], spi.mosi};
      if (spi.mosi !== prev_mosi) mosi_unstable = mosi_unstable + 1;
      if (first_pending) begin
        setup_gap     = cyc - cs_fall_cyc;
        first_pending = 1'b0;
      end else if (cyc - last_rise == 4) begin
        per4_cnt = per4_cnt + 1;
      end else begin
        gap_cnt = gap_cnt + 1;
        if (low_run < gap_min) gap_min = low_run;
      end
      last_rise = cyc;
      low_run   = 0;
    end
    if (sample_valid) valid_cnt = valid_cnt + 1;
    if (sample_valid && prev_valid) valid_long = valid_long + 1;
    prev_cs    = spi.cs;
    prev_sclk  = spi.sclk;
    prev_mosi  = spi.mosi;
    prev_valid = sample_valid;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slave(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
    // Junk in the unused high bits must be ignored by the reader.
    slave_bytes[0] = x[7:0];
    slave_bytes[1] = {6'b101010, x[9:8]};
    slave_bytes[2] = y[7:0];
    slave_bytes[3] = {6'b110011, y[9:8]};
    slave_bytes[4] = {5'b10100, b};
  endtask

  task automatic wait_cs_fall(input string tag);
    int n = 0;
    while (spi.cs !== 1'b0 && n < 600) begin
      step();
      n++;
    end
    check({tag, ".cs_fall_timeout"}, 64'(n < 600), 64'd1);
  endtask

  task automatic do_txn(input string tag, input logic [1:0] led_mid,
                        input logic [9:0] ex, input logic [9:0] ey, input logic [2:0] eb,
                        input logic em, input logic [7:0] emosi0);
    int rise0;
    int n = 0;
    rise0 = rise_cnt;
    wait_cs_fall(tag);
    repeat (20) step();
    led = led_mid;
    while (sample_valid !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check({tag, ".valid_timeout"}, 64'(n < 400), 64'd1);
    check({tag, ".x_pos"}, 64'(x_pos), 64'(ex));
    check({tag, ".y_pos"}, 64'(y_pos), 64'(ey));
    check({tag, ".buttons"}, 64'(buttons), 64'(eb));
    check({tag, ".move_detect"}, 64'(move_detect), 64'(em));
    check({tag, ".sclk_rises"}, 64'(rise_cnt - rise0), 64'd40);
    check({tag, ".mosi_byte0"}, 64'(mosi_cap[39:32]), 64'(emosi0));
    check({tag, ".mosi_bytes1_4"}, 64'(mosi_cap[31:0]), 64'd0);
    step();
    check({tag, ".valid_one_cycle"}, 64'(sample_valid), 64'd0);
  endtask

  initial begin
    int rel;
    int per0, gap0, valid_snap;
    slave_bytes[0] = 8'h00;
    slave_bytes[1] = 8'h02;
    slave_bytes[2] = 8'hFF;
    slave_bytes[3] = 8'h01;
    slave_bytes[4] = 8'h03;

    rst = 1'b0;
    repeat (5) step();
    check("rst.cs", 64'(spi.cs), 64'd1);
    check("rst.sclk", 64'(spi.sclk), 64'd0);
    check("rst.mosi", 64'(spi.mosi), 64'd0);
    check("rst.x_pos", 64'(x_pos), 64'd512);
    check("rst.y_pos", 64'(y_pos), 64'd512);
    check("rst.buttons", 64'(buttons), 64'd0);
    check("rst.move_detect", 64'(move_detect), 64'd0);
    check("rst.valid_cnt", 64'(valid_cnt), 64'd0);

    rel  = cyc;
    rst  = 1'b1;
    per0 = per4_cnt;
    gap0 = gap_cnt;
    do_txn("t1", 2'b00, 10'd512, 10'd511, 3'b011, 1'b0, 8'h80);
    check("t1.first_cs_fall", 64'(cs_fall_cyc - rel), 64'd400);
    check("t1.setup_ge6", 64'(setup_gap >= 6), 64'd1);
    check("t1.period4_count", 64'(per4_cnt - per0), 64'd35);
    check("t1.gap_count", 64'(gap_cnt - gap0), 64'd4);
    check("t1.gap_low_ge4", 64'(gap_min >= 4), 64'd1);

    led = 2'b01;
    set_slave(10'd713, 10'd512, 3'b000);
    do_txn("t2", 2'b10, 10'd713, 10'd512, 3'b000, 1'b1, 8'h81);
    check("t2.poll_period", 64'(cs_fall_cyc - prev_cs_fall_cyc), 64'd400);

    set_slave(10'd712, 10'd512, 3'b001);
    do_txn("t3", 2'b10, 10'd712, 10'd512, 3'b001, 1'b0, 8'h82);

    set_slave(10'd512, 10'd311, 3'b010);
    do_txn("t4", 2'b10, 10'd512, 10'd311, 3'b010, 1'b1, 8'h82);

    set_slave(10'd512, 10'd312, 3'b101);
    do_txn("t5", 2'b10, 10'd512, 10'd312, 3'b101, 1'b0, 8'h82);

    // Abort a transaction during byte 2, then let the next poll complete.
    set_slave(10'd100, 10'd900, 3'b110);
    valid_snap = valid_cnt;
    wait_cs_fall("t6a");
    begin
      int n = 0;
      int r0;
      r0 = rise_cnt;
      while (rise_cnt - r0 < 17 && n < 300) begin
        step();
        n++;
      end
      check("t6a.byte2_timeout", 64'(n < 300), 64'd1);
    end
    rst = 1'b0;
    step();
    check("t6a.cs", 64'(spi.cs), 64'd1);
    check("t6a.sclk", 64'(spi.sclk), 64'd0);
    check("t6a.y_pos", 64'(y_pos), 64'd512);
    check("t6a.buttons", 64'(buttons), 64'd0);
    check("t6a.valid", 64'(sample_valid), 64'd0);
    step();
    step();
    rel = cyc;
    rst = 1'b1;
    do_txn("t6", 2'b10, 10'd100, 10'd900, 3'b110, 1'b1, 8'h82);
    check("t6.first_cs_fall", 64'(cs_fall_cyc - rel), 64'd400);
    check("t6.valid_pulses", 64'(valid_cnt - valid_snap), 64'd1);

    check("all.mosi_stable", 64'(mosi_unstable), 64'd0);
    check("all.valid_width", 64'(valid_long), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
